// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package : mips_pkg
// Brief   : Shared state encoding and opcode constants for the MIPS run sequencer
// Rev     : 1.0  initial release
// ============================================================================
package mips_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_DUMP = 3'd4
  } state_t;

  localparam logic [5:0] C_HLT_OPCODE = 6'h3f;

endpackage
`default_nettype wire

// File: rtl/prog_buf_ram.sv
`default_nettype none
// ============================================================================
// Module : prog_buf_ram
// Brief  : Simple dual-port program buffer, one write port, registered read
// Rev    : 1.0  initial release
// ============================================================================
module prog_buf_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    rd_data <= r_mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/mips_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module : mips_test_sequencer
// Brief  : Initialises CPU registers, loads the program, runs to HLT/timeout
//          and streams out the first DUMP_COUNT registers.
// Rev    : 1.0  initial release
// ============================================================================
module mips_test_sequencer
  import mips_pkg::*;
#(
  parameter int DW         = 32,
  parameter int PROG_DEPTH = 16,
  parameter int AW         = 4,
  parameter int NUM_REGS   = 32,
  parameter int RAW        = 5,
  parameter int DUMP_COUNT = 6,
  parameter int RUN_MAX    = 1024,
  parameter int INIT_MODE  = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           ld_we,
  input  logic [AW-1:0]  ld_addr,
  input  logic [DW-1:0]  ld_data,
  output logic           cpu_hold,
  output logic           cpu_reg_we,
  output logic [RAW-1:0] cpu_reg_addr,
  output logic [DW-1:0]  cpu_reg_wdata,
  input  logic [DW-1:0]  cpu_reg_rdata,
  output logic           cpu_mem_we,
  output logic [AW-1:0]  cpu_mem_addr,
  output logic [DW-1:0]  cpu_mem_wdata,
  input  logic           cpu_halted,
  output logic           dump_valid,
  input  logic           dump_ready,
  output logic [RAW-1:0] dump_idx,
  output logic [DW-1:0]  dump_data,
  output logic           busy,
  output logic           done,
  output logic           timed_out
);

  localparam int CW = $clog2(RUN_MAX + NUM_REGS + PROG_DEPTH + 1) + 1;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic            w_set_timeout;

  logic [AW:0]     r_prog_count;
  logic [RAW-1:0]  r_didx;
  logic            r_dvalid;
  logic            r_cap;
  logic [DW-1:0]   r_ddata;
  logic            r_done;
  logic            r_timed_out;

  logic            w_start_ok;
  logic            w_ld_ok;
  logic            w_dump_xfer;
  logic            w_last_word;
  logic [AW-1:0]   w_rd_addr;
  logic [DW-1:0]   w_rd_data;

  assign w_start_ok  = (r_state == S_IDLE) && start;
  assign w_ld_ok     = (r_state == S_IDLE) && ld_we;
  assign w_dump_xfer = (r_state == S_DUMP) && r_dvalid && dump_ready;
  assign w_last_word = (r_didx == RAW'(DUMP_COUNT - 1));

  // Read runs one word ahead of the write so LOAD copies one word per cycle.
  assign w_rd_addr = (r_state == S_LOAD) ? (r_cnt[AW-1:0] + AW'(1)) : '0;

  prog_buf_ram #(
    .DW    (DW),
    .DEPTH (PROG_DEPTH),
    .AW    (AW)
  ) u_prog_buf (
    .clk     (clk),
    .wr_en   (w_ld_ok),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_addr (w_rd_addr),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_set_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_INIT;
          w_cnt_next   = '0;
        end
      end
      S_INIT: begin
        if (r_cnt == CW'(NUM_REGS - 1)) begin
          if (r_prog_count == '0) begin
            w_state_next = S_RUN;
            w_cnt_next   = CW'(1);
          end else begin
            w_state_next = S_LOAD;
            w_cnt_next   = '0;
          end
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_LOAD: begin
        if (r_cnt == (CW'(r_prog_count) - CW'(1))) begin
          w_state_next = S_RUN;
          w_cnt_next   = CW'(1);
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_RUN: begin
        // HLT wins over a coincident timeout.
        if (cpu_halted) begin
          w_state_next = S_DUMP;
        end else if (r_cnt == CW'(RUN_MAX)) begin
          w_state_next  = S_DUMP;
          w_set_timeout = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_DUMP: begin
        if (w_dump_xfer && w_last_word) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prog_count <= '0;
      r_didx       <= '0;
      r_dvalid     <= 1'b0;
      r_cap        <= 1'b0;
      r_ddata      <= '0;
      r_done       <= 1'b0;
      r_timed_out  <= 1'b0;
    end else begin
      r_done <= w_dump_xfer && w_last_word;

      if (w_ld_ok && ({1'b0, ld_addr} >= r_prog_count)) begin
        r_prog_count <= {1'b0, ld_addr} + (AW+1)'(1);
      end

      if (w_start_ok) begin
        r_timed_out <= 1'b0;
      end else if (w_set_timeout) begin
        r_timed_out <= 1'b1;
      end

      // Word i: address in one cycle, valid the next; data frozen once captured.
      if (r_state != S_DUMP) begin
        r_didx   <= '0;
        r_dvalid <= 1'b0;
        r_cap    <= 1'b0;
      end else if (!r_dvalid) begin
        r_dvalid <= 1'b1;
      end else if (dump_ready) begin
        r_dvalid <= 1'b0;
        r_cap    <= 1'b0;
        r_didx   <= r_didx + RAW'(1);
      end else if (!r_cap) begin
        r_cap   <= 1'b1;
        r_ddata <= cpu_reg_rdata;
      end
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign cpu_hold      = (r_state != S_RUN);
  assign cpu_reg_we    = (r_state == S_INIT);
  assign cpu_reg_addr  = (r_state == S_INIT) ? r_cnt[RAW-1:0] :
                         (r_state == S_DUMP) ? r_didx : '0;
  assign cpu_reg_wdata = ((r_state == S_INIT) && (INIT_MODE == 0)) ?
                         DW'(r_cnt[RAW-1:0]) : '0;
  assign cpu_mem_we    = (r_state == S_LOAD);
  assign cpu_mem_addr  = (r_state == S_LOAD) ? r_cnt[AW-1:0] : '0;
  assign cpu_mem_wdata = (r_state == S_LOAD) ? w_rd_data : '0;
  assign dump_valid    = r_dvalid;
  assign dump_idx      = r_dvalid ? r_didx : '0;
  assign dump_data     = r_dvalid ? (r_cap ? r_ddata : cpu_reg_rdata) : '0;
  assign done          = r_done;
  assign timed_out     = r_timed_out;

endmodule
`default_nettype wire

// File: tb/tb_mips_test_sequencer.sv
`default_nettype none
// Bench for mips_test_sequencer: a tiny non-pipelined CPU stand-in executes
// ADD/OR/ADDI/HLT so the sequencer can be exercised end to end.
module tb_mips_test_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ld_we = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        cpu_hold;
  logic        cpu_reg_we;
  logic [4:0]  cpu_reg_addr;
  logic [31:0] cpu_reg_wdata;
  logic [31:0] cpu_reg_rdata;
  logic        cpu_mem_we;
  logic [3:0]  cpu_mem_addr;
  logic [31:0] cpu_mem_wdata;
  logic        cpu_halted;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        busy;
  logic        done;
  logic        timed_out;

  always #5 clk = ~clk;

  mips_test_sequencer #(
    .DW(32), .PROG_DEPTH(16), .AW(4), .NUM_REGS(32), .RAW(5),
    .DUMP_COUNT(6), .RUN_MAX(64), .INIT_MODE(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .cpu_hold(cpu_hold),
    .cpu_reg_we(cpu_reg_we), .cpu_reg_addr(cpu_reg_addr),
    .cpu_reg_wdata(cpu_reg_wdata), .cpu_reg_rdata(cpu_reg_rdata),
    .cpu_mem_we(cpu_mem_we), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_halted(cpu_halted),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data),
    .busy(busy), .done(done), .timed_out(timed_out)
  );

  // ---------------- CPU stand-in ----------------
  logic [31:0] m_regs [32];
  logic [31:0] m_imem [16];
  logic [3:0]  m_pc = '0;
  logic        m_halted = 1'b0;
  logic [31:0] m_rdata = '0;

  assign cpu_reg_rdata = m_rdata;
  assign cpu_halted    = m_halted;

  always @(posedge clk) begin
    if (cpu_reg_we) m_regs[cpu_reg_addr] <= cpu_reg_wdata;
    if (cpu_mem_we) m_imem[cpu_mem_addr] <= cpu_mem_wdata;
    m_rdata <= m_regs[cpu_reg_addr];
    if (cpu_hold) begin
      m_pc     <= '0;
      m_halted <= 1'b0;
    end else if (!m_halted) begin
      case (m_imem[m_pc][31:26])
        6'h3f: m_halted <= 1'b1;
        6'h00: m_regs[m_imem[m_pc][15:11]] <= m_regs[m_imem[m_pc][25:21]] + m_regs[m_imem[m_pc][20:16]];
        6'h03: m_regs[m_imem[m_pc][15:11]] <= m_regs[m_imem[m_pc][25:21]] | m_regs[m_imem[m_pc][20:16]];
        6'h0a: m_regs[m_imem[m_pc][20:16]] <= m_regs[m_imem[m_pc][25:21]] +
                                              {{16{m_imem[m_pc][15]}}, m_imem[m_pc][15:0]};
        default: ;
      endcase
      if (m_imem[m_pc][31:26] != 6'h3f) m_pc <= m_pc + 4'd1;
    end
  end

  // ---------------- activity monitor ----------------
  int   cyc = 0;
  int   n_reg_we = 0;
  int   n_mem_we = 0;
  int   n_run = 0;
  int   n_both = 0;
  int   n_we_in_run = 0;
  int   run_start_cyc = 0;
  logic prev_hold = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (cpu_reg_we) n_reg_we++;
      if (cpu_mem_we) n_mem_we++;
      if (cpu_reg_we && cpu_mem_we) n_both++;
      if (busy && !cpu_hold) begin
        n_run++;
        if (prev_hold) run_start_cyc = cyc;
        if (cpu_reg_we || cpu_mem_we) n_we_in_run++;
      end
    end
    prev_hold = cpu_hold;
  end

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  int start_cyc = 0;
  int n_words = 0;
  int n_unstable = 0;
  logic [4:0]  got_idx  [6];
  logic [31:0] got_data [6];

  logic [31:0] prog [9] = '{32'h2801000a, 32'h28020014, 32'h28030019,
                            32'h0ce73800, 32'h0ce73800, 32'h00222000,
                            32'h0ce73800, 32'h00832800, 32'hfc000000};
  logic [31:0] exp_prog [6] = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd30, 32'd55};
  localparam logic [31:0] OR_NOP = 32'h0ce73800;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    step();
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic load_word(input int a, input logic [31:0] d);
    step();
    ld_we   = 1'b1;
    ld_addr = a[3:0];
    ld_data = d;
  endtask

  // Waits through the run and accepts six dump words, stalling `gap` cycles each.
  // Leaves the bench one cycle after the final accept.
  task automatic collect(input int gap);
    int hold;
    bit stalled;
    logic [4:0]  sidx;
    logic [31:0] sdata;
    int t;
    n_words = 0; n_unstable = 0; hold = 0; stalled = 0; t = 0;
    sidx = '0; sdata = '0;
    dump_ready = (gap == 0);
    while (n_words < 6 && t < 3000) begin
      step();
      t++;
      if (dump_valid) begin
        if (stalled && (dump_idx !== sidx || dump_data !== sdata)) n_unstable++;
        if (hold < gap) begin
          dump_ready = 1'b0;
          hold++;
          stalled = 1'b1;
          sidx = dump_idx;
          sdata = dump_data;
        end else begin
          dump_ready = 1'b1;
          got_idx[n_words]  = dump_idx;
          got_data[n_words] = dump_data;
          n_words++;
          hold = 0;
          stalled = 1'b0;
        end
      end else begin
        dump_ready = (gap == 0);
      end
    end
    step();
    dump_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_hold got=%b exp=1", cpu_hold); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (cpu_reg_we !== 1'b0 || cpu_mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b%b exp=00", cpu_reg_we, cpu_mem_we); end
    checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", dump_valid); end
    checks++; if (done !== 1'b0 || timed_out !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", done, timed_out); end
    rst = 1'b0;
  endtask

  task automatic test_program();
    int r0, m0;
    for (int i = 0; i < 9; i++) load_word(i, prog[i]);
    step();
    ld_we = 1'b0;
    r0 = n_reg_we; m0 = n_mem_we;
    pulse_start();
    collect(0);
    checks++; if (n_words !== 6) begin errors++; $display("FAIL prog_words got=%0d exp=6", n_words); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_idx[i] !== 5'(i) || got_data[i] !== exp_prog[i]) begin
        errors++; $display("FAIL prog_dump[%0d] got idx=%0d data=%0d exp idx=%0d data=%0d", i, got_idx[i], got_data[i], i, exp_prog[i]);
      end
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL prog_done got done=%b busy=%b exp 1 0", done, busy); end
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL prog_timed_out got=%b exp=0", timed_out); end
    checks++; if (n_reg_we - r0 !== 32 || n_mem_we - m0 !== 9) begin errors++; $display("FAIL prog_writes got reg=%0d mem=%0d exp 32 9", n_reg_we - r0, n_mem_we - m0); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL prog_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_start_ignored();
    int r0, m0, t;
    r0 = n_reg_we; m0 = n_mem_we;
    pulse_start();
    repeat (5) step();
    start = 1'b1; ld_we = 1'b1; ld_addr = 4'd15; ld_data = 32'hfc000000;
    step();
    start = 1'b0; ld_we = 1'b0;
    t = 0;
    while (cpu_hold && t < 200) begin step(); t++; end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL ign_reach_run got hold=%b exp=0", cpu_hold); end
    start = 1'b1;
    step();
    start = 1'b0;
    collect(0);
    checks++; if (n_reg_we - r0 !== 32 || n_mem_we - m0 !== 9) begin errors++; $display("FAIL ign_writes got reg=%0d mem=%0d exp 32 9", n_reg_we - r0, n_mem_we - m0); end
    checks++; if (n_words !== 6 || got_data[5] !== 32'd55) begin errors++; $display("FAIL ign_result got words=%0d r5=%0d exp 6 55", n_words, got_data[5]); end
    // Second run reveals whether the busy-time ld_we changed the program length.
    m0 = n_mem_we;
    pulse_start();
    collect(0);
    checks++; if (n_mem_we - m0 !== 9) begin errors++; $display("FAIL ign_ld_we got mem=%0d exp=9", n_mem_we - m0); end
    checks++; if (got_data[5] !== 32'd55) begin errors++; $display("FAIL ign_rerun got r5=%0d exp=55", got_data[5]); end
  endtask

  task automatic test_backpressure();
    pulse_start();
    collect(3);
    checks++; if (n_unstable !== 0) begin errors++; $display("FAIL bp_stable got unstable=%0d exp=0", n_unstable); end
    checks++; if (n_words !== 6) begin errors++; $display("FAIL bp_words got=%0d exp=6", n_words); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_idx[i] !== 5'(i) || got_data[i] !== exp_prog[i]) begin
        errors++; $display("FAIL bp_dump[%0d] got idx=%0d data=%0d exp idx=%0d data=%0d", i, got_idx[i], got_data[i], i, exp_prog[i]);
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got=%b exp=1", done); end
  endtask

  task automatic test_timeout();
    int n0;
    for (int i = 0; i < 16; i++) load_word(i, OR_NOP);
    step();
    ld_we = 1'b0;
    n0 = n_run;
    pulse_start();
    collect(0);
    checks++; if (n_run - n0 !== 64) begin errors++; $display("FAIL to_run_cycles got=%0d exp=64", n_run - n0); end
    checks++; if (timed_out !== 1'b1) begin errors++; $display("FAIL to_flag got=%b exp=1", timed_out); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL to_done got=%b exp=1", done); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_idx[i] !== 5'(i) || got_data[i] !== 32'(i)) begin
        errors++; $display("FAIL to_dump[%0d] got idx=%0d data=%0d exp %0d", i, got_idx[i], got_data[i], i);
      end
    end
  endtask

  task automatic test_midload_reset();
    int t;
    pulse_start();
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL mid_to_clear got=%b exp=0", timed_out); end
    t = 0;
    while (!(cpu_mem_we && cpu_mem_addr == 4'd4) && t < 200) begin step(); t++; end
    checks++; if (cpu_mem_we !== 1'b1 || cpu_mem_addr !== 4'd4) begin errors++; $display("FAIL mid_reach_word4 got we=%b addr=%0d exp 1 4", cpu_mem_we, cpu_mem_addr); end
    rst = 1'b1;
    step();
    checks++; if (cpu_hold !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_state got hold=%b busy=%b exp 1 0", cpu_hold, busy); end
    checks++; if (cpu_reg_we !== 1'b0 || cpu_mem_we !== 1'b0 || dump_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_strobes got %b%b%b exp 000", cpu_reg_we, cpu_mem_we, dump_valid); end
    rst = 1'b0;
  endtask

  task automatic test_no_load();
    int m0;
    m0 = n_mem_we;
    pulse_start();
    collect(0);
    checks++; if (n_mem_we - m0 !== 0) begin errors++; $display("FAIL noload_mem got=%0d exp=0", n_mem_we - m0); end
    // Start is sampled at the edge after start_cyc; 32 INIT cycles follow, then RUN.
    checks++; if (run_start_cyc - start_cyc !== 33) begin errors++; $display("FAIL noload_latency got=%0d exp=33", run_start_cyc - start_cyc); end
    checks++; if (n_words !== 6 || timed_out !== 1'b1) begin errors++; $display("FAIL noload_dump got words=%0d to=%b exp 6 1", n_words, timed_out); end
  endtask

  task automatic test_strobes();
    checks++; if (n_both !== 0) begin errors++; $display("FAIL strobe_both got=%0d exp=0", n_both); end
    checks++; if (n_we_in_run !== 0) begin errors++; $display("FAIL strobe_in_run got=%0d exp=0", n_we_in_run); end
  endtask

  initial begin
    test_reset();
    test_program();
    test_start_ignored();
    test_backpressure();
    test_timeout();
    test_midload_reset();
    test_no_load();
    test_strobes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
